// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI master byte engine across n_req requesters,
// with chip-select setup/gap timing and a per-byte completion timeout.
module spi_xfer_arbiter #(
   parameter int N_REQ    = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_GAP   = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [4*N_REQ-1:0] req_len,
   input  logic [8*N_REQ-1:0] tx_data,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   tx_pop,
   output logic [7:0]         rx_data,
   output logic [N_REQ-1:0]   rx_valid,
   output logic [N_REQ-1:0]   done,
   output logic [N_REQ-1:0]   err,
   output logic [N_REQ-1:0]   cs_n,
   output logic               mst_start,
   output logic [7:0]         mst_tx,
   input  logic               mst_done,
   input  logic [7:0]         mst_rx
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, GAP} state_t;
   state_t state;
   logic [IW-1:0] ptr, pick, cand;
   logic [N_REQ-1:0] valid, sel, pick_oh;
   logic [3:0] cnt, len_pick;
   logic [7:0] tmr, tx_cur;
   assign sel = N_REQ'(1) << ptr;
   assign pick_oh = N_REQ'(1) << pick;
   // descending scan so the nearest valid requester after ptr wins
   always_comb begin
      valid = '0;
      len_pick = '0;
      tx_cur = '0;
      pick = ptr;
      cand = ptr;
      for (int i = 0; i < N_REQ; i++) valid[i] = req[i] && (req_len[4*i +: 4] != 4'd0);
      for (int j = N_REQ; j >= 1; j--) begin
         cand = IW'((int'(ptr) + j) % N_REQ);
         if (valid[cand]) pick = cand;
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (IW'(i) == pick) len_pick = req_len[4*i +: 4];
         if (IW'(i) == ptr) tx_cur = tx_data[8*i +: 8];
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= IW'(N_REQ - 1);
         cnt       <= '0;
         tmr       <= '0;
         gnt       <= '0;
         tx_pop    <= '0;
         rx_data   <= '0;
         rx_valid  <= '0;
         done      <= '0;
         err       <= '0;
         cs_n      <= '1;
         mst_start <= 1'b0;
         mst_tx    <= '0;
      end else begin
         mst_start <= 1'b0;
         tx_pop    <= '0;
         rx_valid  <= '0;
         done      <= '0;
         err       <= '0;
         case (state)
            IDLE: if (|valid) begin
               ptr   <= pick;
               gnt   <= pick_oh;
               cs_n  <= ~pick_oh;
               cnt   <= len_pick;
               tmr   <= '0;
               state <= (CS_SETUP == 1) ? START : SETUP;
            end
            SETUP: if (tmr == 8'(CS_SETUP - 2)) state <= START;
                   else tmr <= tmr + 8'd1;
            START: begin
               mst_start <= 1'b1;
               tx_pop    <= sel;
               mst_tx    <= tx_cur;
               tmr       <= '0;
               state     <= WAIT;
            end
            WAIT: if (mst_done) begin
               rx_data  <= mst_rx;
               rx_valid <= sel;
               cnt      <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  cs_n  <= '1;
                  gnt   <= '0;
                  done  <= sel;
                  tmr   <= '0;
                  state <= GAP;
               end else state <= START;
            end else if (tmr == 8'(TIMEOUT - 1)) begin
               cs_n  <= '1;
               gnt   <= '0;
               err   <= sel;
               tmr   <= '0;
               state <= GAP;
            end else tmr <= tmr + 8'd1;
            GAP: if (tmr == 8'(CS_GAP - 1)) state <= IDLE;
                 else tmr <= tmr + 8'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: randomized bursts against a queue-based reference of grants, bytes and
// completions; a monitor pops expectations whenever the arbiter presents an event.
module tb_spi_xfer_arbiter;
   localparam int N = 2, CS_SETUP = 2, CS_GAP = 4, TIMEOUT = 255;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [N-1:0] req = '0;
   logic [4*N-1:0] req_len = '0;
   logic [8*N-1:0] tx_data = '0;
   logic [N-1:0] gnt, tx_pop, rx_valid, done, err, cs_n;
   logic [7:0] rx_data, mst_tx, mst_rx = '0, b2;
   logic mst_start, mst_done = 1'b0;
   int total = 0, bad = 0, cyc = 0, n_start = 0, n_rx = 0, req_cyc = 0;
   int hi_run = CS_GAP + 1, g_cyc = 0, r_cyc = 0, s_cyc = 0;
   bit lat_arm = 0, first = 0, m_en = 1, stray = 0, e;
   logic [N-1:0] pgnt = '0, cur = '0, csx, o, dx, ex;
   int exp_gnt[$], rx_i[$], end_i[$];
   logic [7:0] exp_tx[$], rx_b[$], pat[$];
   bit end_err[$];
   logic [7:0] src [N][$];

   always #5 clk = ~clk;

   spi_xfer_arbiter #(.N_REQ(N), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .tx_data(tx_data),
      .gnt(gnt), .tx_pop(tx_pop), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
      .err(err), .cs_n(cs_n), .mst_start(mst_start), .mst_tx(mst_tx),
      .mst_done(mst_done), .mst_rx(mst_rx));

   function automatic logic [N-1:0] oh(int i);
      return N'(1) << i;
   endfunction

   // round-robin rule: first requesting index after the last winner, wrapping
   function automatic int winner(int p, logic [N-1:0] m);
      for (int j = 1; j <= N; j++) if (m[(p + j) % N]) return (p + j) % N;
      return -1;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_burst(int i, int len);
      logic [7:0] b;
      exp_gnt.push_back(i);
      for (int n = 0; n < len; n++) begin
         b = (pat.size() > 0) ? pat.pop_front() : 8'($urandom);
         src[i].push_back(b);
         exp_tx.push_back(b);
         rx_i.push_back(i);
         rx_b.push_back(~b);
      end
      end_i.push_back(i);
      end_err.push_back(1'b0);
   endtask

   task automatic wait_q(int budget);
      int t = 0;
      while (t < budget && (exp_gnt.size() + exp_tx.size() + rx_b.size() + end_i.size()) != 0) begin
         @(negedge clk);
         t++;
      end
      chk("drain", exp_gnt.size() + exp_tx.size() + rx_b.size() + end_i.size(), 0);
   endtask

   task automatic clear_q();
      exp_gnt.delete(); exp_tx.delete(); rx_i.delete(); rx_b.delete();
      end_i.delete(); end_err.delete();
      for (int i = 0; i < N; i++) src[i].delete();
   endtask

   task automatic single(int i, int len);
      @(negedge clk);
      expect_burst(i, len);
      req_len[4*i +: 4] = 4'(len);
      req[i] = 1'b1;
      req_cyc = cyc + 1;
      lat_arm = 1;
      wait_q(len * 10 + 40);
      @(negedge clk);
      req[i] = 1'b0;
      repeat (CS_GAP + 2) @(negedge clk);
   endtask

   // requesters present the head of their byte queue
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) tx_data[8*i +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
   end

   // SPI master stand-in: echoes the inverted byte after a random latency
   initial forever begin
      @(posedge clk); #1;
      if (stray) begin
         @(negedge clk);
         mst_rx = 8'h77;
         mst_done = 1'b1;
         @(negedge clk);
         mst_done = 1'b0;
         stray = 0;
      end else if (rst_n && m_en && mst_start) begin
         b2 = mst_tx;
         repeat ($urandom_range(1, 4)) @(negedge clk);
         mst_rx = ~b2;
         mst_done = 1'b1;
         @(negedge clk);
         mst_done = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
         pgnt = '0;
         hi_run = CS_GAP + 1;
         first = 0;
         continue;
      end
      for (int i = 0; i < N; i++) if (tx_pop[i] && src[i].size() > 0) void'(src[i].pop_front());
      if (gnt != '0 && pgnt == '0) begin
         if (exp_gnt.size() > 0) begin
            cur = oh(exp_gnt.pop_front());
            csx = ~cur;
            chk("gnt", gnt, cur);
            chk("cs_low", cs_n, csx);
         end else chk("gnt_unexpected", gnt, 0);
         chk("cs_gap_ok", hi_run >= CS_GAP + 1, 1);
         if (lat_arm) begin
            chk("gnt_latency", cyc, req_cyc);
            lat_arm = 0;
         end
         g_cyc = cyc;
         first = 1;
      end
      hi_run = (cs_n == '1) ? hi_run + 1 : 0;
      if (mst_start) begin
         n_start++;
         if (exp_tx.size() > 0) chk("mst_tx", mst_tx, exp_tx.pop_front());
         else chk("start_unexpected", mst_start, 0);
         chk("tx_pop", tx_pop, cur);
         chk("start_timing", first ? cyc - g_cyc : cyc - r_cyc, first ? CS_SETUP : 1);
         first = 0;
         s_cyc = cyc;
      end
      if (rx_valid != '0) begin
         n_rx++;
         r_cyc = cyc;
         if (rx_b.size() > 0) begin
            chk("rx_valid", rx_valid, oh(rx_i.pop_front()));
            chk("rx_data", rx_data, rx_b.pop_front());
         end else chk("rx_unexpected", rx_valid, 0);
      end
      if ((done | err) != '0) begin
         if (end_i.size() > 0) begin
            o = oh(end_i.pop_front());
            e = end_err.pop_front();
            dx = e ? '0 : o;
            ex = e ? o : '0;
            chk("done", done, dx);
            chk("err", err, ex);
            chk("cs_release", cs_n, {N{1'b1}});
            chk("gnt_release", gnt, 0);
            if (!e) chk("done_with_rx", rx_valid, o);
            else chk("timeout_len", cyc - s_cyc, TIMEOUT);
         end else chk("end_unexpected", done | err, 0);
      end
      pgnt = gnt;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      int mp, w, base;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_tx_pop", tx_pop, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_mst_start", mst_start, 0);
      chk("rst_mst_tx", mst_tx, 0);
      chk("rst_cs_n", cs_n, {N{1'b1}});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pat = '{8'hA5, 8'h3C, 8'hFF};
      single(0, 3);
      repeat (8) single(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 15)));

      @(negedge clk);
      req_len[7:4] = 4'd0;
      req = 2'b10;
      repeat (30) @(negedge clk);
      chk("zero_len_gnt", gnt, 0);
      chk("zero_len_cs", cs_n, 2'b11);
      req = '0;
      repeat (2) @(negedge clk);

      m_en = 0;
      b = 8'($urandom);
      exp_gnt.push_back(1);
      src[1].push_back(b);
      src[1].push_back(8'($urandom));
      exp_tx.push_back(b);
      end_i.push_back(1);
      end_err.push_back(1'b1);
      req_len[7:4] = 4'd2;
      req[1] = 1'b1;
      req_cyc = cyc + 1;
      lat_arm = 1;
      wait_q(TIMEOUT + 60);
      @(negedge clk);
      req[1] = 1'b0;
      src[1].delete();
      base = n_rx;
      stray = 1;
      for (int t = 0; t < 10 && stray; t++) @(negedge clk);
      repeat (CS_GAP + 4) @(negedge clk);
      stray = 1;
      for (int t = 0; t < 10 && stray; t++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("stray_done_rx", n_rx, base);
      m_en = 1;

      @(negedge clk);
      expect_burst(0, 4);
      req_len[3:0] = 4'd4;
      req[0] = 1'b1;
      req_cyc = cyc + 1;
      lat_arm = 1;
      base = n_start;
      for (int t = 0; t < 200 && n_start < base + 2; t++) begin
         @(posedge clk);
         #2;
      end
      chk("reach_byte2", n_start - base, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_gnt", gnt, 0);
      chk("abort_cs", cs_n, {N{1'b1}});
      chk("abort_start", mst_start, 0);
      req = '0;
      lat_arm = 0;
      clear_q();
      repeat (10) @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      mp = N - 1;
      for (int k = 0; k < 4; k++) begin
         w = winner(mp, {N{1'b1}});
         expect_burst(w, 1);
         mp = w;
      end
      req_len = {4'd1, 4'd1};
      req = 2'b11;
      req_cyc = cyc + 1;
      lat_arm = 1;
      wait_q(300);
      @(negedge clk);
      req = '0;
      repeat (CS_GAP + 4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
